countdown_ctrl: RTL and testbench

// - Run-control FSM for the EGo1 countdown timer.
// - Takes the six BCD preset digits from the digit editor (MM:SS.cc, cc = centiseconds) and loads them.
// - Counts them down to 00:00.00 at a 10 ms tick, and handles start/pause/clear from the push buttons.
// - Drives the display digits, the editor enable and the alarm output.

---
 rtl/countdown_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Run-control FSM for the countdown timer: loads a BCD MM:SS.cc preset, counts it
// down on a 10 ms tick, handles start/pause/clear. Optional macro: TIMER_ALARM_BLINK_EN.
module countdown_ctrl #(
    parameter int TICK_DIV    = 1_000_000,
    parameter int BLINK_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       clr_btn,
    input  logic [3:0] ld_min_10,
    input  logic [3:0] ld_min_1,
    input  logic [3:0] ld_sec_10,
    input  logic [3:0] ld_sec_1,
    input  logic [3:0] ld_ms_10,
    input  logic [3:0] ld_ms_1,
    output logic [3:0] cur_min_10,
    output logic [3:0] cur_min_1,
    output logic [3:0] cur_sec_10,
    output logic [3:0] cur_sec_1,
    output logic [3:0] cur_ms_10,
    output logic [3:0] cur_ms_1,
    output logic [1:0] state,
    output logic       edit_en,
    output logic       tick,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_SET   = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_tick_div_chk
        $error("countdown_ctrl: TICK_DIV must be >= 2");
    end
    if (BLINK_TICKS < 1) begin : g_blink_chk
        $error("countdown_ctrl: BLINK_TICKS must be >= 1");
    end

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_v);
        if (d > max_v) begin
            return max_v;
        end else begin
            return d;
        end
    endfunction

    // One BCD step down, digits packed {min10,min1,sec10,sec1,cc10,cc1}, lowest first in the chain.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  dig;
        logic [3:0]  rel;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dig = v[i*4 +: 4];
            rel = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (!borrow) begin
                r[i*4 +: 4] = dig;
            end else if (dig == 4'd0) begin
                r[i*4 +: 4] = rel;
                borrow      = 1'b1;
            end else begin
                r[i*4 +: 4] = dig - 4'd1;
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [23:0]   cur_q, cur_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          edit_en_q, edit_en_d;
    logic          tick_q, tick_d;
    logic          alarm_q, alarm_d;
    logic [2:0]    start_sync_q, start_sync_d;
    logic [2:0]    clr_sync_q, clr_sync_d;
    logic          start_press_q, start_press_d;
    logic          clr_press_q, clr_press_d;

    logic [23:0]   ld_s;
    logic          ld_nz_s;
    logic          presc_run_s;
    logic          wrap_s;

    assign ld_s = {clamp_digit(ld_min_10, 4'd5), clamp_digit(ld_min_1, 4'd9),
                   clamp_digit(ld_sec_10, 4'd5), clamp_digit(ld_sec_1, 4'd9),
                   clamp_digit(ld_ms_10,  4'd9), clamp_digit(ld_ms_1,  4'd9)};
    assign ld_nz_s = |ld_s;

    // Button synchronizers: [0],[1] sync stages, [2] previous level for the falling-edge detect.
    always_comb begin
        start_sync_d  = {start_sync_q[1:0], start_btn};
        clr_sync_d    = {clr_sync_q[1:0], clr_btn};
        start_press_d = start_sync_q[2] & ~start_sync_q[1];
        clr_press_d   = clr_sync_q[2] & ~clr_sync_q[1];
    end

    // Prescaler run enable and wrap strobe.
    always_comb begin
        presc_run_s = (state_q == ST_RUN);
`ifdef TIMER_ALARM_BLINK_EN
        presc_run_s = presc_run_s || (state_q == ST_DONE);
`endif
        wrap_s = presc_run_s && (presc_q == PRESC_MAX);
    end

    // Run-control next state and display value.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            ST_SET: begin
                cur_d = ld_s;
                if (start_press_q && !clr_press_q && ld_nz_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SET;
                end
            end
            ST_RUN: begin
                if (clr_press_q) begin
                    state_d = ST_SET;
                    cur_d   = ld_s;
                end else if (wrap_s) begin
                    // The expiring tick wins over a simultaneous pause request.
                    if (cur_q <= 24'h000001) begin
                        cur_d   = 24'h000000;
                        state_d = ST_DONE;
                    end else if (start_press_q) begin
                        cur_d   = bcd_dec(cur_q);
                        state_d = ST_PAUSE;
                    end else begin
                        cur_d   = bcd_dec(cur_q);
                        state_d = ST_RUN;
                    end
                end else if (start_press_q) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clr_press_q) begin
                    state_d = ST_SET;
                    cur_d   = ld_s;
                end else if (start_press_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (clr_press_q || start_press_q) begin
                    state_d = ST_SET;
                    cur_d   = ld_s;
                end else begin
                    state_d = ST_DONE;
                    cur_d   = 24'h000000;
                end
            end
            default: begin
                state_d = ST_SET;
                cur_d   = ld_s;
            end
        endcase
    end

    // Prescaler, tick strobe and editor enable.
    always_comb begin
        if (state_q == ST_SET || state_d == ST_SET) begin
            presc_d = '0;
        end else if (wrap_s) begin
            presc_d = '0;
        end else if (presc_run_s) begin
            presc_d = presc_q + PW'(1);
        end else begin
            presc_d = presc_q;
        end
        tick_d    = wrap_s;
        edit_en_d = (state_d == ST_SET);
    end

`ifdef TIMER_ALARM_BLINK_EN
    localparam int            BW        = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    logic [BW-1:0] blink_q, blink_d;

    // Alarm blink: starts high on DONE entry, toggles every BLINK_TICKS ticks.
    always_comb begin
        if (state_d != ST_DONE) begin
            alarm_d = 1'b0;
            blink_d = '0;
        end else if (state_q != ST_DONE) begin
            alarm_d = 1'b1;
            blink_d = '0;
        end else if (wrap_s) begin
            if (blink_q == BLINK_MAX) begin
                alarm_d = ~alarm_q;
                blink_d = '0;
            end else begin
                alarm_d = alarm_q;
                blink_d = blink_q + BW'(1);
            end
        end else begin
            alarm_d = alarm_q;
            blink_d = blink_q;
        end
    end

    // Blink tick counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    // Steady alarm while expired.
    always_comb begin
        alarm_d = (state_d == ST_DONE);
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_SET;
            cur_q         <= 24'h000000;
            presc_q       <= '0;
            edit_en_q     <= 1'b1;
            tick_q        <= 1'b0;
            alarm_q       <= 1'b0;
            start_sync_q  <= 3'b111;
            clr_sync_q    <= 3'b111;
            start_press_q <= 1'b0;
            clr_press_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            presc_q       <= presc_d;
            edit_en_q     <= edit_en_d;
            tick_q        <= tick_d;
            alarm_q       <= alarm_d;
            start_sync_q  <= start_sync_d;
            clr_sync_q    <= clr_sync_d;
            start_press_q <= start_press_d;
            clr_press_q   <= clr_press_d;
        end
    end

    assign cur_min_10 = cur_q[23:20];
    assign cur_min_1  = cur_q[19:16];
    assign cur_sec_10 = cur_q[15:12];
    assign cur_sec_1  = cur_q[11:8];
    assign cur_ms_10  = cur_q[7:4];
    assign cur_ms_1   = cur_q[3:0];
    assign state      = state_q;
    assign edit_en    = edit_en_q;
    assign tick       = tick_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV = 4, BLINK_TICKS = 2.
// Digit values are shown as packed BCD hex {min10,min1,sec10,sec1,cc10,cc1}.
module tb_countdown_ctrl;

    localparam int TD = 4;
    localparam int BT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_btn = 1'b1;
    logic        clr_btn = 1'b1;
    logic [23:0] ld_all = 24'h000000;
    logic [3:0]  cur_min_10, cur_min_1, cur_sec_10, cur_sec_1, cur_ms_10, cur_ms_1;
    logic [1:0]  state;
    logic        edit_en, tick, alarm;
    logic [23:0] cur_all;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] ld;
        logic [23:0] exp_cur;
    } vec_t;
    vec_t vecs[7];

    assign cur_all = {cur_min_10, cur_min_1, cur_sec_10, cur_sec_1, cur_ms_10, cur_ms_1};

    countdown_ctrl #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn  (start_btn),
        .clr_btn    (clr_btn),
        .ld_min_10  (ld_all[23:20]),
        .ld_min_1   (ld_all[19:16]),
        .ld_sec_10  (ld_all[15:12]),
        .ld_sec_1   (ld_all[11:8]),
        .ld_ms_10   (ld_all[7:4]),
        .ld_ms_1    (ld_all[3:0]),
        .cur_min_10 (cur_min_10),
        .cur_min_1  (cur_min_1),
        .cur_sec_10 (cur_sec_10),
        .cur_sec_1  (cur_sec_1),
        .cur_ms_10  (cur_ms_10),
        .cur_ms_1   (cur_ms_1),
        .state      (state),
        .edit_en    (edit_en),
        .tick       (tick),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Hold the pin(s) low across two sampling edges, then release.
    task automatic press(input logic s, input logic c);
        start_btn = s ? 1'b0 : 1'b1;
        clr_btn   = c ? 1'b0 : 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_btn = 1'b1;
        clr_btn   = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] exp, input int budget, input string name);
        int n;
        n = 0;
        while (state !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, state, exp);
    endtask

    task automatic wait_tick(input int budget, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < budget);
        chk(name, tick, 1'b1);
    endtask

    initial begin
        int n;
        int bad;
        int seen;
        logic bl[5];

        vecs[0] = '{24'h010000, 24'h010000};
        vecs[1] = '{24'h123456, 24'h123456};
        vecs[2] = '{24'h595999, 24'h595999};
        vecs[3] = '{24'h9F7ACE, 24'h595999};
        vecs[4] = '{24'h6A6B0C, 24'h595909};
        vecs[5] = '{24'h000000, 24'h000000};
        vecs[6] = '{24'h453219, 24'h453219};
        bl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset values, while in reset and just after release.
        repeat (3) @(negedge clk);
        chk("rst_cur", cur_all, 24'h000000);
        chk("rst_state", state, 2'b00);
        chk("rst_edit_en", edit_en, 1'b1);
        chk("rst_tick", tick, 1'b0);
        chk("rst_alarm", alarm, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_cur", cur_all, 24'h000000);
        chk("rel_state", state, 2'b00);

        // SET mode loading and clamping.
        for (int i = 0; i < 7; i++) begin
            ld_all = vecs[i].ld;
            @(negedge clk);
            chk($sformatf("set_load_%0d", i), cur_all, vecs[i].exp_cur);
            chk($sformatf("set_state_%0d", i), state, 2'b00);
            chk($sformatf("set_edit_%0d", i), edit_en, 1'b1);
        end

        // Borrow chain from 01:00.00.
        ld_all = 24'h010000;
        @(negedge clk);
        press(1'b1, 1'b0);
        wait_state(2'b01, 6, "borrow_run");
        chk("borrow_edit_off", edit_en, 1'b0);
        wait_tick(10, "borrow_tick1", n);
        chk("first_tick_lat", n, 4);
        chk("borrow_t1", cur_all, 24'h005999);
        wait_tick(10, "borrow_tick2", n);
        chk("borrow_t2", cur_all, 24'h005998);
        chk("borrow_state", state, 2'b01);
        press(1'b0, 1'b1);
        wait_state(2'b00, 6, "borrow_clear");

        // Expiry from 00:00.02.
        ld_all = 24'h000002;
        @(negedge clk);
        press(1'b1, 1'b0);
        wait_state(2'b01, 6, "exp_run");
        wait_tick(10, "exp_tick1", n);
        chk("exp_t1", cur_all, 24'h000001);
        chk("exp_t1_state", state, 2'b01);
        wait_tick(10, "exp_tick2", n);
        chk("exp_t2", cur_all, 24'h000000);
        chk("exp_done", state, 2'b11);
        chk("exp_alarm", alarm, 1'b1);
`ifdef TIMER_ALARM_BLINK_EN
        for (int k = 1; k < 5; k++) begin
            wait_tick(10, "blink_tick", n);
            chk($sformatf("blink_%0d", k), alarm, bl[k]);
        end
`else
        seen = 0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (tick === 1'b1) seen++;
            if (alarm !== 1'b1 || cur_all !== 24'h000000) bad++;
        end
        chk("done_steady", bad, 0);
        chk("done_tick_idle", seen, 0);
        chk("done_alarm", alarm, bl[0]);
`endif
        press(1'b1, 1'b0);
        wait_state(2'b00, 6, "done_to_set");
        chk("set_alarm_off", alarm, 1'b0);
        chk("set_edit_on", edit_en, 1'b1);

        // Pause one cycle after the third tick, then resume.
        ld_all = 24'h001000;
        @(negedge clk);
        press(1'b1, 1'b0);
        wait_state(2'b01, 6, "pause_run");
        wait_tick(10, "pause_tick1", n);
        wait_tick(10, "pause_tick2", n);
        @(negedge clk);
        press(1'b1, 1'b0);
        @(negedge clk);
        chk("pause_tick3", tick, 1'b1);
        chk("pause_t3", cur_all, 24'h000997);
        @(negedge clk);
        chk("pause_state", state, 2'b10);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (cur_all !== 24'h000997 || state !== 2'b10 || tick !== 1'b0) bad++;
        end
        chk("pause_hold", bad, 0);
        press(1'b1, 1'b0);
        wait_state(2'b01, 6, "resume_run");
        wait_tick(10, "resume_tick", n);
        chk("resume_lat", n, 3);
        chk("resume_t4", cur_all, 24'h000996);

        // Start and clear together during RUN: clear wins.
        ld_all = 24'h000500;
        press(1'b0, 1'b1);
        wait_state(2'b00, 6, "sim_pre_set");
        @(negedge clk);
        press(1'b1, 1'b0);
        wait_state(2'b01, 6, "sim_run");
        repeat (2) @(negedge clk);
        press(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("sim_set", state, 2'b00);
        ld_all = 24'h020304;
        @(negedge clk);
        chk("sim_follow", cur_all, 24'h020304);
        chk("sim_edit", edit_en, 1'b1);

        // All-zero preset: start ignored.
        ld_all = 24'h000000;
        @(negedge clk);
        press(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        chk("zero_stay_set", state, 2'b00);
        chk("zero_cur", cur_all, 24'h000000);

        // Asynchronous reset mid-count, then a clean restart.
        ld_all = 24'h030000;
        @(negedge clk);
        press(1'b1, 1'b0);
        wait_state(2'b01, 6, "ar_run");
        wait_tick(10, "ar_tick", n);
        chk("ar_t1", cur_all, 24'h025999);
        #2 rst = 1'b0;
        #1;
        chk("ar_cur", cur_all, 24'h000000);
        chk("ar_state", state, 2'b00);
        chk("ar_edit", edit_en, 1'b1);
        chk("ar_tick0", tick, 1'b0);
        chk("ar_alarm", alarm, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_reload", cur_all, 24'h030000);
        press(1'b1, 1'b0);
        wait_state(2'b01, 6, "ar_rerun");
        wait_tick(10, "ar_retick", n);
        chk("ar_presc_clean", n, 4);
        chk("ar_re_t1", cur_all, 24'h025999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
